// File: rtl/xm23_alu.sv
// xm23_alu: registered arithmetic/logic unit for the XM23 datapath.
// Computes one of 17 operations on d_bus/s_bus each enabled cycle and
// registers the result together with an updated PSW (C, Z, N, V merged
// into the incoming PSW, all other bits passed through).

module xm23_alu (
    input  logic        Clock,
    input  logic        rst_n,
    input  logic [15:0] d_bus,
    input  logic [15:0] s_bus,
    input  logic [5:0]  alu_op,
    input  logic [15:0] psw_in,
    input  logic        alu_E,
    input  logic        psw_update,
    output logic [15:0] alu_out,
    output logic [15:0] psw_out
);

    // Operation codes carried in alu_op[4:0]; 17..31 behave as NOP.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_ADDC = 5'd1,
        OP_SUB  = 5'd2,
        OP_SUBC = 5'd3,
        OP_DADD = 5'd4,
        OP_CMP  = 5'd5,
        OP_XOR  = 5'd6,
        OP_AND  = 5'd7,
        OP_OR   = 5'd8,
        OP_BIT  = 5'd9,
        OP_BIC  = 5'd10,
        OP_BIS  = 5'd11,
        OP_MOV  = 5'd12,
        OP_SRA  = 5'd13,
        OP_RRC  = 5'd14,
        OP_SWPB = 5'd15,
        OP_SXT  = 5'd16
    } op_t;

    localparam logic [15:0] PSW_RESET = 16'h60E0;

    op_t         op_code;
    logic        byte_mode;
    logic        carry_flag;

    logic [15:0] b_term;
    logic        add_cin;
    logic [16:0] sum_word;
    logic [8:0]  sum_byte;

    logic [15:0] bcd_sum;
    logic        bcd_c8;
    logic        bcd_c16;
    logic        bcd_carry;
    logic [4:0]  nib_sum;

    logic [15:0] logic_val;
    logic [15:0] flag_val;
    logic [15:0] result;
    logic        op_c;
    logic        op_v;
    logic        set_c;
    logic        set_nzv;
    logic        flag_n;
    logic        flag_z;
    logic [15:0] psw_next;

    assign op_code    = op_t'(alu_op[4:0]);
    assign byte_mode  = alu_op[5] && (alu_op[4:0] <= 5'd14);
    assign carry_flag = psw_in[0];

    // Select the adder's second operand and carry-in for the add/subtract family.
    always_comb begin
        b_term  = s_bus;
        add_cin = 1'b0;
        case (op_code)
            OP_ADDC: add_cin = carry_flag;
            OP_SUB, OP_CMP: begin
                b_term  = ~s_bus;
                add_cin = 1'b1;
            end
            OP_SUBC: begin
                b_term  = ~s_bus;
                add_cin = carry_flag;
            end
            default: ;
        endcase
    end

    assign sum_word = {1'b0, d_bus} + {1'b0, b_term} + {16'd0, add_cin};
    assign sum_byte = {1'b0, d_bus[7:0]} + {1'b0, b_term[7:0]} + {8'd0, add_cin};

    // Nibble-serial BCD adder; the carry out of nibble 1 serves byte mode.
    always_comb begin
        bcd_carry = carry_flag;
        bcd_sum   = '0;
        bcd_c8    = 1'b0;
        nib_sum   = '0;
        for (int i = 0; i < 4; i++) begin
            nib_sum = {1'b0, d_bus[4*i +: 4]} + {1'b0, s_bus[4*i +: 4]} + {4'd0, bcd_carry};
            if (nib_sum > 5'd9) begin
                nib_sum   = nib_sum + 5'd6;
                bcd_carry = 1'b1;
            end else begin
                bcd_carry = 1'b0;
            end
            bcd_sum[4*i +: 4] = nib_sum[3:0];
            if (i == 1) begin
                bcd_c8 = bcd_carry;
            end
        end
        bcd_c16 = bcd_carry;
    end

    // Bitwise operations on the full word; byte mode later keeps d_bus[15:8].
    always_comb begin
        case (op_code)
            OP_XOR:         logic_val = d_bus ^ s_bus;
            OP_AND, OP_BIT: logic_val = d_bus & s_bus;
            OP_OR,  OP_BIS: logic_val = d_bus | s_bus;
            OP_BIC:         logic_val = d_bus & ~s_bus;
            default:        logic_val = d_bus;
        endcase
    end

    // Per-operation result, the value flags are derived from, and which flags change.
    always_comb begin
        result   = d_bus;
        flag_val = d_bus;
        op_c     = carry_flag;
        op_v     = 1'b0;
        set_c    = 1'b0;
        set_nzv  = 1'b0;
        case (op_code)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                if (byte_mode) begin
                    flag_val = {d_bus[15:8], sum_byte[7:0]};
                    op_c     = sum_byte[8];
                    op_v     = (d_bus[7] == b_term[7]) && (sum_byte[7] != d_bus[7]);
                end else begin
                    flag_val = sum_word[15:0];
                    op_c     = sum_word[16];
                    op_v     = (d_bus[15] == b_term[15]) && (sum_word[15] != d_bus[15]);
                end
                set_c   = 1'b1;
                set_nzv = 1'b1;
                result  = (op_code == OP_CMP) ? d_bus : flag_val;
            end
            OP_DADD: begin
                if (byte_mode) begin
                    flag_val = {d_bus[15:8], bcd_sum[7:0]};
                    op_c     = bcd_c8;
                end else begin
                    flag_val = bcd_sum;
                    op_c     = bcd_c16;
                end
                set_c   = 1'b1;
                set_nzv = 1'b1;
                result  = flag_val;
            end
            OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
                flag_val = byte_mode ? {d_bus[15:8], logic_val[7:0]} : logic_val;
                set_nzv  = 1'b1;
                result   = (op_code == OP_BIT) ? d_bus : flag_val;
            end
            OP_MOV: begin
                result = byte_mode ? {d_bus[15:8], s_bus[7:0]} : s_bus;
            end
            OP_SRA: begin
                flag_val = byte_mode ? {d_bus[15:8], d_bus[7], d_bus[7:1]}
                                     : {d_bus[15], d_bus[15:1]};
                op_c     = d_bus[0];
                set_c    = 1'b1;
                set_nzv  = 1'b1;
                result   = flag_val;
            end
            OP_RRC: begin
                flag_val = byte_mode ? {d_bus[15:8], carry_flag, d_bus[7:1]}
                                     : {carry_flag, d_bus[15:1]};
                op_c     = d_bus[0];
                set_c    = 1'b1;
                set_nzv  = 1'b1;
                result   = flag_val;
            end
            OP_SWPB: begin
                result = {d_bus[7:0], d_bus[15:8]};
            end
            OP_SXT: begin
                flag_val = {{8{d_bus[7]}}, d_bus[7:0]};
                set_nzv  = 1'b1;
                result   = flag_val;
            end
            default: ;
        endcase
    end

    assign flag_n = byte_mode ? flag_val[7] : flag_val[15];
    assign flag_z = byte_mode ? (flag_val[7:0] == 8'h00) : (flag_val == 16'h0000);

    // Merge the changed flags into the incoming PSW only when an update is requested.
    always_comb begin
        psw_next = psw_in;
        if (psw_update) begin
            if (set_nzv) begin
                psw_next[1] = flag_z;
                psw_next[2] = flag_n;
                psw_next[4] = op_v;
            end
            if (set_c) begin
                psw_next[0] = op_c;
            end
        end
    end

    // Output registers: reset wins over enable, disabled cycles hold.
    always_ff @(posedge Clock) begin
        if (!rst_n) begin
            alu_out <= 16'h0000;
            psw_out <= PSW_RESET;
        end else if (alu_E) begin
            alu_out <= result;
            psw_out <= psw_next;
        end
    end

endmodule

// File: tb/tb_xm23_alu.sv
// tb_xm23_alu: directed and randomized checks of xm23_alu against an
// integer-arithmetic reference model of the XM23 operation rules.

module tb_xm23_alu;

    logic        Clock;
    logic        rst_n;
    logic [15:0] d_bus;
    logic [15:0] s_bus;
    logic [5:0]  alu_op;
    logic [15:0] psw_in;
    logic        alu_E;
    logic        psw_update;
    logic [15:0] alu_out;
    logic [15:0] psw_out;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [15:0] exp_out = 16'h0000;
    logic [15:0] exp_psw = 16'h60E0;

    xm23_alu dut (
        .Clock      (Clock),
        .rst_n      (rst_n),
        .d_bus      (d_bus),
        .s_bus      (s_bus),
        .alu_op     (alu_op),
        .psw_in     (psw_in),
        .alu_E      (alu_E),
        .psw_update (psw_update),
        .alu_out    (alu_out),
        .psw_out    (psw_out)
    );

    // Free-running clock, 10 time units per period.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%04h, wanted 0x%04h", tag, observed, expected);
        end
    endtask

    // Convert a packed BCD value of 'digits' digits to an integer.
    function automatic int bcd_to_int(input int v, input int digits);
        int acc = 0;
        int scale = 1;
        for (int k = 0; k < digits; k++) begin
            acc   = acc + ((v >> (4 * k)) & 15) * scale;
            scale = scale * 10;
        end
        return acc;
    endfunction

    // Convert an integer back to packed BCD of 'digits' digits.
    function automatic int int_to_bcd(input int v, input int digits);
        int acc = 0;
        int rem = v;
        for (int k = 0; k < digits; k++) begin
            acc = acc | ((rem % 10) << (4 * k));
            rem = rem / 10;
        end
        return acc;
    endfunction

    // Random 16-bit value made only of decimal digits.
    function automatic logic [15:0] rand_bcd();
        int v = 0;
        for (int k = 0; k < 4; k++) begin
            v = v | (int'($urandom_range(0, 9)) << (4 * k));
        end
        return 16'(v);
    endfunction

    // Reference model: result and PSW that one enabled cycle should produce.
    task automatic model_alu(input logic [15:0] d, input logic [15:0] s,
                             input logic [5:0] op, input logic [15:0] psw,
                             input logic upd,
                             output logic [15:0] res, output logic [15:0] psw_o);
        int code  = int'(op[4:0]);
        int w     = (op[5] && code <= 14) ? 8 : 16;
        int mask  = (1 << w) - 1;
        int half  = 1 << (w - 1);
        int a     = int'(d) & mask;
        int sv    = int'(s) & mask;
        int ci    = int'(psw[0]);
        int b     = 0;
        int cin   = 0;
        int total = 0;
        int sa    = 0;
        int sb    = 0;
        int r     = a;
        int c     = ci;
        int v     = 0;
        int full  = 0;
        bit touch_c   = 0;
        bit touch_nzv = 0;
        bit keep_d    = 0;
        case (code)
            0, 1, 2, 3, 5: begin
                b   = (code == 2 || code == 3 || code == 5) ? ((~int'(s)) & mask) : sv;
                cin = (code == 0) ? 0 : ((code == 2 || code == 5) ? 1 : ci);
                total = a + b + cin;
                r  = total & mask;
                c  = (total >> w) & 1;
                sa = (a >= half) ? a - (1 << w) : a;
                sb = (b >= half) ? b - (1 << w) : b;
                v  = ((sa + sb + cin) > half - 1 || (sa + sb + cin) < -half) ? 1 : 0;
                touch_c = 1; touch_nzv = 1;
                keep_d = (code == 5);
            end
            4: begin
                total = bcd_to_int(a, w / 4) + bcd_to_int(sv, w / 4) + ci;
                c = (total >= ((w == 8) ? 100 : 10000)) ? 1 : 0;
                r = int_to_bcd(total % ((w == 8) ? 100 : 10000), w / 4);
                touch_c = 1; touch_nzv = 1;
            end
            6:  begin r = a ^ sv;           touch_nzv = 1; end
            7:  begin r = a & sv;           touch_nzv = 1; end
            8:  begin r = a | sv;           touch_nzv = 1; end
            9:  begin r = a & sv;           touch_nzv = 1; keep_d = 1; end
            10: begin r = a & ~sv & mask;   touch_nzv = 1; end
            11: begin r = a | sv;           touch_nzv = 1; end
            12: r = sv;
            13: begin
                r = (a >> 1) | (a & half);
                c = a & 1;
                touch_c = 1; touch_nzv = 1;
            end
            14: begin
                r = (a >> 1) | (ci * half);
                c = a & 1;
                touch_c = 1; touch_nzv = 1;
            end
            15: r = ((int'(d) & 255) << 8) | (int'(d) >> 8);
            16: begin
                r = ((int'(d) & 128) != 0) ? ((int'(d) & 255) | 16'hFF00) : (int'(d) & 255);
                touch_nzv = 1;
            end
            default: r = int'(d);
        endcase
        full  = (int'(d) & ~mask & 16'hFFFF) | r;
        res   = keep_d ? d : 16'(full);
        psw_o = psw;
        if (upd) begin
            if (touch_nzv) begin
                psw_o[1] = (r == 0);
                psw_o[2] = ((r & half) != 0);
                psw_o[4] = (v != 0);
            end
            if (touch_c) begin
                psw_o[0] = (c != 0);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the expected state, check both outputs.
    task automatic applyStimulus(input string tag, input logic rst, input logic en,
                                 input logic [5:0] op, input logic [15:0] d,
                                 input logic [15:0] s, input logic [15:0] psw,
                                 input logic upd);
        logic [15:0] m_res;
        logic [15:0] m_psw;
        rst_n      = rst;
        alu_E      = en;
        alu_op     = op;
        d_bus      = d;
        s_bus      = s;
        psw_in     = psw;
        psw_update = upd;
        model_alu(d, s, op, psw, upd, m_res, m_psw);
        @(posedge Clock);
        #1;
        if (!rst) begin
            exp_out = 16'h0000;
            exp_psw = 16'h60E0;
        end else if (en) begin
            exp_out = m_res;
            exp_psw = m_psw;
        end
        checkOutput({tag, "_out"}, alu_out, exp_out);
        checkOutput({tag, "_psw"}, psw_out, exp_psw);
    endtask

    initial begin
        logic [5:0]  r_op;
        logic [15:0] r_d;
        logic [15:0] r_s;

        rst_n = 1'b0; alu_E = 1'b0; alu_op = '0; d_bus = '0; s_bus = '0;
        psw_in = '0; psw_update = 1'b0;
        #2;

        // Reset with enable high must still give the reset values.
        applyStimulus("reset", 1'b0, 1'b1, 6'd0, 16'h1234, 16'h1111, 16'hFFFF, 1'b1);
        checkOutput("reset_out_const", alu_out, 16'h0000);
        checkOutput("reset_psw_const", psw_out, 16'h60E0);

        applyStimulus("add_ovf", 1'b1, 1'b1, 6'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1);
        checkOutput("add_ovf_out_const", alu_out, 16'h8000);
        checkOutput("add_ovf_psw_const", psw_out, 16'h0014);

        applyStimulus("sub_eq", 1'b1, 1'b1, 6'd2, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        checkOutput("sub_eq_out_const", alu_out, 16'h0000);
        checkOutput("sub_eq_psw_const", psw_out, 16'h0003);

        applyStimulus("cmp_eq", 1'b1, 1'b1, 6'd5, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        checkOutput("cmp_eq_out_const", alu_out, 16'h0005);
        checkOutput("cmp_eq_psw_const", psw_out, 16'h0003);

        applyStimulus("addb", 1'b1, 1'b1, 6'h20, 16'h12FF, 16'h0001, 16'h0000, 1'b1);
        checkOutput("addb_out_const", alu_out, 16'h1200);
        checkOutput("addb_psw_const", psw_out, 16'h0003);

        applyStimulus("dadd", 1'b1, 1'b1, 6'd4, 16'h0099, 16'h0001, 16'h0000, 1'b1);
        checkOutput("dadd_out_const", alu_out, 16'h0100);
        checkOutput("dadd_psw_const", psw_out, 16'h0000);

        applyStimulus("rrc", 1'b1, 1'b1, 6'd14, 16'h0002, 16'h0000, 16'h0001, 1'b1);
        checkOutput("rrc_out_const", alu_out, 16'h8001);
        checkOutput("rrc_psw_const", psw_out, 16'h0004);

        applyStimulus("sra", 1'b1, 1'b1, 6'd13, 16'h8003, 16'h0000, 16'h0000, 1'b1);
        checkOutput("sra_out_const", alu_out, 16'hC001);
        checkOutput("sra_psw_const", psw_out, 16'h0005);

        applyStimulus("noupd", 1'b1, 1'b1, 6'd0, 16'hFFFF, 16'h0001, 16'h1234, 1'b0);
        checkOutput("noupd_out_const", alu_out, 16'h0000);
        checkOutput("noupd_psw_const", psw_out, 16'h1234);

        // Disabled cycles with changing inputs must hold the outputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("hold", 1'b1, 1'b0, 6'd11, 16'hA5A5 + 16'(i), 16'h0F0F,
                          16'h0000, 1'b1);
            checkOutput("hold_out_const", alu_out, 16'h0000);
            checkOutput("hold_psw_const", psw_out, 16'h1234);
        end

        applyStimulus("passthru", 1'b1, 1'b1, 6'd0, 16'h7FFF, 16'h0001, 16'hE0E8, 1'b1);
        checkOutput("passthru_psw_const", psw_out, 16'hE0FC);

        applyStimulus("midrst", 1'b0, 1'b1, 6'd12, 16'h0000, 16'hBEEF, 16'h0000, 1'b1);
        checkOutput("midrst_out_const", alu_out, 16'h0000);
        checkOutput("midrst_psw_const", psw_out, 16'h60E0);

        // Randomized operations, byte/word mode, enables, updates and occasional resets.
        for (int i = 0; i < 600; i++) begin
            r_op = 6'($urandom_range(0, 63));
            if (r_op[4:0] == 5'd4) begin
                r_d = rand_bcd();
                r_s = rand_bcd();
            end else begin
                r_d = 16'($urandom);
                r_s = 16'($urandom);
            end
            applyStimulus("rand", ($urandom_range(0, 29) != 0), ($urandom_range(0, 7) != 0),
                          r_op, r_d, r_s, 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
